rtg_pixel_unpack: RTL and testbench
===================================

RTG_PIXEL_UNPACK -- requirements
Module: rtg_pixel_unpack

Interface
REQ-001 SHALL have parameter DATA_W, default 16, fetch word width; legal values 16 or 32.
REQ-002 SHALL have parameter DIV_W, default 6, pixel divider width.
REQ-003 SHALL have port clk_114 input 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port reset input 1, asynchronous active-high reset.
REQ-005 SHALL have port ena input 1, RTG display enable.
REQ-006 SHALL have port blank input 1, combined h/v blank, already synchronised to clk_114.
REQ-007 SHALL have port pixelwidth input DIV_W, clocks per pixel minus 1.
REQ-008 SHALL have port mode input 2, pixel format: 0=8-bit CLUT, 1=15-bit 555, 2=16-bit 565, 3=32-bit xRGB.
REQ-009 SHALL have ports clut_wr input 1, clut_idx input 8, clut_d input 24, CLUT write port.
REQ-010 SHALL have ports fifo_q input DATA_W, fifo_empty input 1, fifo_rdreq output 1, show-ahead stream FIFO.
REQ-011 SHALL have ports red, green, blue output 8 each, registered pixel colour.
REQ-012 SHALL have ports pixel output 1, de output 1, underrun output 1, underrun_clr input 1.

Function
REQ-013 SHALL count clocks 0..pixelwidth while ena and !blank; the count==pixelwidth cycle is a pixel slot; the counter is held at 0 during blank.
REQ-014 SHALL latch mode only while blank is high; a mode change mid-line takes effect at the next blank.
REQ-015 SHALL hold the current fetch word in a holding register with a sub-index; pixels per word are DATA_W/8 (mode 0), DATA_W/16 (modes 1,2), DATA_W/32 (mode 3); most significant pixel first.
REQ-016 SHALL assert fifo_rdreq for exactly one cycle when a pixel slot finds the sub-index exhausted and fifo_empty is low; fifo_q is loaded the same cycle.
REQ-017 SHALL, in mode 3 with DATA_W=16, use a two-state assembler (HI, LO): first pop loads bits 31:16, second pop (next cycle) loads bits 15:0; a pixel emits only after LO.
REQ-018 SHALL expand 5-bit fields as {f,f[4:2]} and 6-bit fields as {f,f[5:4]}; mode 3 uses bits 23:0 directly.
REQ-019 SHALL emit pixel and RGB exactly 2 cycles after the pixel slot in every mode, with CLUT read latency included; direct modes are delayed to match.
REQ-020 SHALL drive de = delayed(!blank & ena), aligned with RGB.
REQ-021 SHALL, on a pixel slot needing a pop while fifo_empty is high, output black for that pixel, not advance the sub-index, and set underrun.
REQ-022 SHALL hold underrun sticky until underrun_clr; if set and clear coincide, set wins.
REQ-023 SHALL keep the holding register and sub-index across blank, with no discard.
REQ-024 SHALL make a CLUT write and a same-index read in the same cycle return old data.
REQ-025 SHALL, when ena is low, drive fifo_rdreq=0, pixel=0, de=0 and RGB=0, and reset the sub-index to exhausted.

Reset
REQ-026 SHALL on reset clear the counter, sub-index (exhausted), assembler (HI), latched mode (0), RGB, pixel, de, fifo_rdreq and underrun to 0; CLUT contents are not reset.
REQ-027 SHALL make reset asserted mid-line abandon any partial 32-bit assembly.

Configuration
REQ-028 SHALL gate mode 3 with macro RTG_TRUECOLOUR_EN: when defined, mode 3 is per REQ-015..017; when undefined, mode 3 behaves as mode 2 and the assembler is omitted.

Structure
REQ-029 SHALL place mode encodings, assembler state type and field-expansion constants in package rtg_pkg.
REQ-030 SHALL implement the CLUT as sub-module rtg_clut_ram, 256x24, with a synchronous read and one write port.

Verification
REQ-031 SHALL cover: mode 0, DATA_W=16, pixelwidth=3, fifo word 0x1234, CLUT[0x12]=0xFF0000, CLUT[0x34]=0x00FF00 -> red then green pixels, 4 clocks apart, one rdreq.
REQ-032 SHALL cover: mode 2, word 0xF800 -> RGB=FF,00,00; mode 1, word 0x7FFF -> FF,FF,FF; latency 2 cycles from slot.
REQ-033 SHALL cover: mode 3, DATA_W=16, words 0x0012, 0x3456 -> two consecutive rdreq, RGB=12,34,56.
REQ-034 SHALL cover: fifo_empty high at a pop slot -> black pixel, underrun=1; underrun_clr and a new underrun in the same cycle -> underrun stays 1.
REQ-035 SHALL cover: mode written 0->2 mid-line -> unchanged until blank, mode 2 from the first pixel after blank.
REQ-036 SHALL cover: reset pulsed between HI and LO pops -> all outputs 0, next mode 3 pixel needs two fresh pops.

Source files
------------

// File: rtl/rtg_pkg.sv
// Shared pixel-format encodings, truecolour assembler state and colour field expansion
// for the RTG pixel unpacker.
package rtg_pkg;

  localparam logic [1:0] MODE_CLUT8  = 2'd0;
  localparam logic [1:0] MODE_RGB555 = 2'd1;
  localparam logic [1:0] MODE_RGB565 = 2'd2;
  localparam logic [1:0] MODE_XRGB32 = 2'd3;

  typedef enum logic {
    ASM_HI = 1'b0,
    ASM_LO = 1'b1
  } asm_state_t;

  // Replicate the top bits into the vacated LSBs so full-scale fields map to 0xFF.
  function automatic logic [7:0] exp5(input logic [4:0] f);
    return {f, f[4:2]};
  endfunction

  function automatic logic [7:0] exp6(input logic [5:0] f);
    return {f, f[5:4]};
  endfunction

endpackage

// File: rtl/rtg_clut_ram.sv
// 256x24 colour lookup table: one write port, one synchronous read port.
// A same-address write and read in one cycle returns the previous contents.
module rtg_clut_ram (
  input  logic        clk,
  input  logic        wr,
  input  logic [7:0]  widx,
  input  logic [23:0] wd,
  input  logic [7:0]  ridx,
  output logic [23:0] rd
);

  logic [23:0] mem [0:255];

  always_ff @(posedge clk) begin
    if (wr) mem[widx] <= wd;
    rd <= mem[ridx];
  end

endmodule

// File: rtl/rtg_pixel_unpack.sv
// RTG pixel unpacker: pops packed words from a show-ahead FIFO and emits one RGB pixel
// per pixel slot, two clocks after the slot. Mode 3 truecolour gated by RTG_TRUECOLOUR_EN.
module rtg_pixel_unpack
  import rtg_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DIV_W  = 6
) (
  input  logic              clk_114,
  input  logic              reset,
  input  logic              ena,
  input  logic              blank,
  input  logic [DIV_W-1:0]  pixelwidth,
  input  logic [1:0]        mode,
  input  logic              clut_wr,
  input  logic [7:0]        clut_idx,
  input  logic [23:0]       clut_d,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              fifo_empty,
  output logic              fifo_rdreq,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              pixel,
  output logic              de,
  output logic              underrun,
  input  logic              underrun_clr
);

  logic [DIV_W-1:0]  cnt;
  logic [1:0]        mode_q, eff_mode;
  logic [DATA_W-1:0] hold, hold_nxt, src;
  logic [2:0]        left, left_nxt, ppw;
  logic [5:0]        psz;
  logic              slot, take, und_set;
  logic              asm_mode, asm_lo, asm_start, lo_ok;
  logic [23:0]       asm_rgb;
  logic [31:0]       wl;
  logic [23:0]       dir_rgb, clut_q;
  logic [7:0]        clut_addr;
  logic              p1_pix, p1_de, p1_clut, p1_asm;
  logic [23:0]       p1_rgb;

`ifdef RTG_TRUECOLOUR_EN
  asm_state_t asm_q, asm_nxt;
  logic [7:0] hi;

  assign eff_mode = mode_q;
  assign asm_mode = (DATA_W == 16) && (eff_mode == MODE_XRGB32);
  assign asm_lo   = (asm_q == ASM_LO);
  assign asm_rgb  = {hi, fifo_q[15:0]};

  always_ff @(posedge clk_114 or posedge reset) begin
    if (reset) begin
      asm_q <= ASM_HI;
      hi    <= '0;
    end else begin
      asm_q <= ena ? asm_nxt : ASM_HI;
      if (asm_start) hi <= fifo_q[7:0];
    end
  end

  always_comb begin
    asm_nxt = asm_q;
    if (asm_start)           asm_nxt = ASM_LO;
    else if (asm_q == ASM_LO) asm_nxt = ASM_HI;
  end
`else
  assign eff_mode = (mode_q == MODE_XRGB32) ? MODE_RGB565 : mode_q;
  assign asm_mode = 1'b0;
  assign asm_lo   = 1'b0;
  assign asm_rgb  = '0;
`endif

  assign slot = ena && !blank && (cnt == pixelwidth);

  always_comb begin
    ppw = 3'(DATA_W / 32);
    psz = 6'd32;
    case (eff_mode)
      MODE_CLUT8:               begin ppw = 3'(DATA_W / 8);  psz = 6'd8;  end
      MODE_RGB555, MODE_RGB565: begin ppw = 3'(DATA_W / 16); psz = 6'd16; end
      default: ;
    endcase
  end

  // Pop/advance decision; an LO assembler cycle owns the FIFO port.
  always_comb begin
    fifo_rdreq = 1'b0;
    take       = 1'b0;
    src        = hold;
    left_nxt   = left;
    hold_nxt   = hold;
    und_set    = 1'b0;
    asm_start  = 1'b0;
    lo_ok      = 1'b0;
    if (ena && !reset) begin
      if (asm_lo) begin
        if (!fifo_empty) begin
          fifo_rdreq = 1'b1;
          lo_ok      = 1'b1;
        end else begin
          und_set = 1'b1;
        end
        if (slot) und_set = 1'b1;
      end else if (slot) begin
        if (left != 3'd0) begin
          take     = 1'b1;
          left_nxt = 3'(left - 3'd1);
          hold_nxt = hold << psz;
        end else if (fifo_empty) begin
          und_set = 1'b1;
        end else begin
          fifo_rdreq = 1'b1;
          if (asm_mode) begin
            asm_start = 1'b1;
          end else begin
            take     = 1'b1;
            src      = fifo_q;
            left_nxt = 3'(ppw - 3'd1);
            hold_nxt = fifo_q << psz;
          end
        end
      end
    end
  end

  // Left-align the source word so the most significant pixel sits at bit 31.
  assign wl        = 32'(src) << (32 - DATA_W);
  assign clut_addr = wl[31:24];

  always_comb begin
    dir_rgb = wl[23:0];
    case (eff_mode)
      MODE_RGB555: dir_rgb = {exp5(wl[30:26]), exp5(wl[25:21]), exp5(wl[20:16])};
      MODE_RGB565: dir_rgb = {exp5(wl[31:27]), exp6(wl[26:21]), exp5(wl[20:16])};
      default: ;
    endcase
  end

  rtg_clut_ram u_clut (
    .clk  (clk_114),
    .wr   (clut_wr),
    .widx (clut_idx),
    .wd   (clut_d),
    .ridx (clut_addr),
    .rd   (clut_q)
  );

  always_ff @(posedge clk_114 or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      mode_q   <= MODE_CLUT8;
      left     <= '0;
      hold     <= '0;
      underrun <= 1'b0;
    end else begin
      cnt      <= (!ena || blank || slot) ? '0 : DIV_W'(cnt + DIV_W'(1));
      if (blank) mode_q <= mode;
      left     <= ena ? left_nxt : 3'd0;
      hold     <= hold_nxt;
      underrun <= und_set | (underrun & ~underrun_clr);
    end
  end

  // Stage 1 runs alongside the CLUT read; stage 2 is the output register.
  always_ff @(posedge clk_114 or posedge reset) begin
    if (reset) begin
      p1_pix  <= 1'b0;
      p1_de   <= 1'b0;
      p1_clut <= 1'b0;
      p1_asm  <= 1'b0;
      p1_rgb  <= '0;
      pixel   <= 1'b0;
      de      <= 1'b0;
      {red, green, blue} <= '0;
    end else if (!ena) begin
      p1_pix  <= 1'b0;
      p1_de   <= 1'b0;
      p1_clut <= 1'b0;
      p1_asm  <= 1'b0;
      p1_rgb  <= '0;
      pixel   <= 1'b0;
      de      <= 1'b0;
      {red, green, blue} <= '0;
    end else begin
      p1_pix  <= slot;
      p1_de   <= !blank;
      p1_clut <= take && (eff_mode == MODE_CLUT8);
      p1_asm  <= asm_start;
      p1_rgb  <= take ? dir_rgb : 24'h0;
      pixel   <= p1_pix;
      de      <= p1_de;
      if (p1_asm)       {red, green, blue} <= lo_ok ? asm_rgb : 24'h0;
      else if (p1_clut) {red, green, blue} <= clut_q;
      else              {red, green, blue} <= p1_rgb;
    end
  end

endmodule

// File: tb/tb_rtg_pixel_unpack.sv
// Directed bench for rtg_pixel_unpack (DATA_W=16); mode 3 expectations follow RTG_TRUECOLOUR_EN.
module tb_rtg_pixel_unpack;

  logic        clk_114 = 1'b0;
  logic        reset, ena, blank;
  logic [5:0]  pixelwidth;
  logic [1:0]  mode;
  logic        clut_wr;
  logic [7:0]  clut_idx;
  logic [23:0] clut_d;
  logic [15:0] fifo_q;
  logic        fifo_empty, fifo_rdreq;
  logic [7:0]  red, green, blue;
  logic        pixel, de, underrun, underrun_clr;

  int total = 0;
  int bad   = 0;
  int rd    = 0;

`ifdef RTG_TRUECOLOUR_EN
  localparam logic [31:0] EXP_LO_POP = 32'd1;
  localparam logic [31:0] EXP_M3     = 32'h123456;
`else
  localparam logic [31:0] EXP_LO_POP = 32'd0;
  localparam logic [31:0] EXP_M3     = 32'h000094;
`endif

  rtg_pixel_unpack #(.DATA_W(16), .DIV_W(6)) dut (
    .clk_114      (clk_114),
    .reset        (reset),
    .ena          (ena),
    .blank        (blank),
    .pixelwidth   (pixelwidth),
    .mode         (mode),
    .clut_wr      (clut_wr),
    .clut_idx     (clut_idx),
    .clut_d       (clut_d),
    .fifo_q       (fifo_q),
    .fifo_empty   (fifo_empty),
    .fifo_rdreq   (fifo_rdreq),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .pixel        (pixel),
    .de           (de),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk_114 = ~clk_114;

  task automatic step();
    @(negedge clk_114);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One word, one pixel: pop at the 4th clock of the line, pixel two clocks later.
  task automatic run_one(input string tag, input logic [15:0] word, input logic [1:0] m,
                         input logic [31:0] exp_rgb);
    blank = 1'b1; mode = m; fifo_q = word; fifo_empty = 1'b0;
    step(); step();
    blank = 1'b0;
    step(); step(); step();
    chk({tag, "_rdreq"}, 32'(fifo_rdreq), 32'd1);
    step();
    chk({tag, "_early"}, 32'(pixel), 32'd0);
    fifo_empty = 1'b1;
    step();
    chk({tag, "_pixel"}, 32'(pixel), 32'd1);
    chk({tag, "_rgb"}, 32'({red, green, blue}), exp_rgb);
    blank = 1'b1;
  endtask

  // Mode 3: truecolour assembles 0x0012/0x3456; otherwise 0x0012 decodes as 565.
  task automatic run_m3(input string tag);
    blank = 1'b1; mode = 2'd3; fifo_q = 16'h0012; fifo_empty = 1'b0;
    step(); step();
    blank = 1'b0;
    step(); step(); step();
    chk({tag, "_hi_pop"}, 32'(fifo_rdreq), 32'd1);
    @(posedge clk_114); #1 fifo_q = 16'h3456;
    step();
    chk({tag, "_lo_pop"}, 32'(fifo_rdreq), EXP_LO_POP);
    step();
    chk({tag, "_pixel"}, 32'(pixel), 32'd1);
    chk({tag, "_rgb"}, 32'({red, green, blue}), EXP_M3);
    fifo_empty = 1'b1; blank = 1'b1;
  endtask

  initial begin
    reset = 1'b1; ena = 1'b0; blank = 1'b1; pixelwidth = 6'd3; mode = 2'd0;
    clut_wr = 1'b0; clut_idx = 8'h00; clut_d = 24'h0;
    fifo_q = 16'h0; fifo_empty = 1'b1; underrun_clr = 1'b0;
    step(); step();
    chk("rst_pixel", 32'(pixel), 32'd0);
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_rgb", 32'({red, green, blue}), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_rdreq", 32'(fifo_rdreq), 32'd0);
    reset = 1'b0;

    clut_wr = 1'b1; clut_idx = 8'h12; clut_d = 24'hFF0000;
    step();
    clut_idx = 8'h34; clut_d = 24'h00FF00;
    step();
    clut_wr = 1'b0; ena = 1'b1;
    step(); step();

    // CLUT mode, two pixels from 0x1234; mode input flips to 2 mid-line.
    fifo_q = 16'h1234; fifo_empty = 1'b0; blank = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (fifo_rdreq) rd++;
      case (k)
        1: mode = 2'd2;
        3: chk("m0_rdreq", 32'(fifo_rdreq), 32'd1);
        4: begin chk("m0_early", 32'(pixel), 32'd0); fifo_empty = 1'b1; end
        5: begin
          chk("m0_px1", 32'(pixel), 32'd1);
          chk("m0_red", 32'({red, green, blue}), 32'hFF0000);
          chk("m0_de", 32'(de), 32'd1);
        end
        7: chk("m0_no_pop", 32'(fifo_rdreq), 32'd0);
        8: chk("m0_gap", 32'(pixel), 32'd0);
        9: begin
          chk("m0_px2", 32'(pixel), 32'd1);
          chk("m0_green", 32'({red, green, blue}), 32'h00FF00);
          blank = 1'b1;
        end
        12: chk("blank_de", 32'(de), 32'd0);
        default: ;
      endcase
    end
    chk("m0_one_pop", 32'(rd), 32'd1);

    run_one("m2_after_blank", 16'hF800, 2'd2, 32'hFF0000);
    run_one("m1_white", 16'h7FFF, 2'd1, 32'hFFFFFF);
    run_m3("m3");

    // Underrun: empty FIFO at a pop slot, then clear coinciding with a new underrun.
    blank = 1'b1; mode = 2'd2; fifo_empty = 1'b1;
    step(); step();
    blank = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      case (k)
        3: chk("ur_no_pop", 32'(fifo_rdreq), 32'd0);
        4: chk("ur_set", 32'(underrun), 32'd1);
        5: begin
          chk("ur_px", 32'(pixel), 32'd1);
          chk("ur_black", 32'({red, green, blue}), 32'd0);
        end
        6: chk("ur_sticky", 32'(underrun), 32'd1);
        7: underrun_clr = 1'b1;
        8: begin chk("ur_set_wins", 32'(underrun), 32'd1); blank = 1'b1; end
        9: begin
          chk("ur_cleared", 32'(underrun), 32'd0);
          chk("ur_black2", 32'({red, green, blue}), 32'd0);
          underrun_clr = 1'b0;
        end
        default: ;
      endcase
    end

    // Reset between the HI and LO pops of a truecolour pixel.
    mode = 2'd3; fifo_q = 16'hAB00; fifo_empty = 1'b0;
    step(); step();
    blank = 1'b0;
    step(); step(); step();
    chk("rs_first_pop", 32'(fifo_rdreq), 32'd1);
    @(posedge clk_114); #1 reset = 1'b1; fifo_q = 16'h0012;
    step();
    chk("rs_rdreq", 32'(fifo_rdreq), 32'd0);
    chk("rs_pixel", 32'(pixel), 32'd0);
    chk("rs_rgb", 32'({red, green, blue}), 32'd0);
    chk("rs_de", 32'(de), 32'd0);
    reset = 1'b0; blank = 1'b1;
    step();
    chk("rs_no_lo", 32'(fifo_rdreq), 32'd0);
    run_m3("rs_m3");

    // Display disabled: nothing popped or emitted even with a slot every clock.
    ena = 1'b0; pixelwidth = 6'd0; blank = 1'b0; fifo_empty = 1'b0;
    step(); step(); step();
    chk("off_rdreq", 32'(fifo_rdreq), 32'd0);
    chk("off_pixel", 32'(pixel), 32'd0);
    chk("off_de", 32'(de), 32'd0);
    chk("off_rgb", 32'({red, green, blue}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
